// File: rtl/pc.sv
// Program-counter register: registers PC_input on each rising CLK edge, with a synchronous active-low reset.
// Optional macro PC_ALIGN_EN forces bits [1:0] of every stored value, including RESET_VALUE, to zero.
module pc #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] PC_input,
    output logic [WIDTH-1:0] PC_output
);

`ifdef PC_ALIGN_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
`else
    localparam logic [WIDTH-1:0] ALIGN_MASK = '1;
`endif

    logic [WIDTH-1:0] pc_q;

    // Reset has priority and makes the block ignore PC_input on that edge.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            pc_q <= RESET_VALUE & ALIGN_MASK;
        end else begin
            pc_q <= PC_input & ALIGN_MASK;
        end
    end

    assign PC_output = pc_q;

endmodule

// File: tb/tb_pc.sv
// Directed, table-driven bench for pc, with hand-written sequences for mid-cycle input and reset changes.
// Two instances are used: one with the default RESET_VALUE and one with a non-zero, unaligned RESET_VALUE.
module tb_pc;

    localparam logic [31:0] RV1 = 32'h0000_1003;

    logic        CLK;
    logic        reset;
    logic [31:0] PC_input;
    logic [31:0] out0;
    logic [31:0] out1;

    int checks = 0;
    int errors = 0;

    pc #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut0 (
        .CLK(CLK), .reset(reset), .PC_input(PC_input), .PC_output(out0)
    );

    pc #(.WIDTH(32), .RESET_VALUE(RV1)) dut1 (
        .CLK(CLK), .reset(reset), .PC_input(PC_input), .PC_output(out1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] al(input logic [31:0] x);
`ifdef PC_ALIGN_EN
        return x & 32'hFFFF_FFFC;
`else
        return x;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit expired");
    end

    initial begin
        logic [31:0] held0;
        logic [31:0] held1;

        vecs[0]  = '{1'b0, 32'd100,        32'd0,                al(RV1)};
        vecs[1]  = '{1'b0, 32'd100,        32'd0,                al(RV1)};
        vecs[2]  = '{1'b1, 32'd100,        32'd100,              32'd100};
        vecs[3]  = '{1'b1, 32'd200,        32'd200,              32'd200};
        vecs[4]  = '{1'b1, 32'd300,        32'd300,              32'd300};
        vecs[5]  = '{1'b0, 32'd500,        32'd0,                al(RV1)};
        vecs[6]  = '{1'b1, 32'd500,        32'd500,              32'd500};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFF,  al(32'hFFFF_FFFF),    al(32'hFFFF_FFFF)};
        vecs[8]  = '{1'b1, 32'h0000_0000,  32'h0000_0000,        32'h0000_0000};
        vecs[9]  = '{1'b1, 32'hA5A5_A5A6,  al(32'hA5A5_A5A6),    al(32'hA5A5_A5A6)};
        vecs[10] = '{1'b1, 32'h5A5A_5A59,  al(32'h5A5A_5A59),    al(32'h5A5A_5A59)};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd0,                al(RV1)};
        vecs[12] = '{1'b1, 32'h0000_0007,  al(32'h0000_0007),    al(32'h0000_0007)};

        reset    = 1'b0;
        PC_input = 32'd100;

        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            reset    = vecs[i].rst;
            PC_input = vecs[i].din;
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_dut0", i), out0, vecs[i].exp0);
            check($sformatf("vec%0d_dut1", i), out1, vecs[i].exp1);
        end

        // Mid-cycle input change: output holds until the next rising edge.
        @(negedge CLK);
        reset    = 1'b1;
        PC_input = 32'd300;
        @(posedge CLK);
        #1;
        check("mid_load300", out0, 32'd300);
        #2;
        PC_input = 32'd400;
        #1;
        check("mid_hold300_a", out0, 32'd300);
        @(negedge CLK);
        #1;
        check("mid_hold300_b", out0, 32'd300);
        @(posedge CLK);
        #1;
        check("mid_load400", out0, 32'd400);
        check("mid_load400_dut1", out1, 32'd400);

        // Reset pulsed low strictly between edges has no effect.
        held0 = out0;
        held1 = out1;
        #1;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("glitch_hold_dut0", out0, held0);
        check("glitch_hold_dut1", out1, held1);
        @(negedge CLK);
        PC_input = 32'd600;
        @(posedge CLK);
        #1;
        check("glitch_then_load", out0, 32'd600);
        check("glitch_then_load_dut1", out1, 32'd600);

        // Reset asserted just before an edge overrides the pending load; release loads PC_input.
        @(negedge CLK);
        PC_input = 32'd700;
        reset    = 1'b0;
        @(posedge CLK);
        #1;
        check("override_dut0", out0, 32'd0);
        check("override_dut1", out1, al(RV1));
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check("release_load", out0, 32'd700);
        check("release_load_dut1", out1, 32'd700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc.md
PC -- requirements
Module: pc

Interface
REQ-001 Parameter WIDTH, default 32, sets the bit width of PC_input and PC_output.
REQ-002 Parameter RESET_VALUE, default 32'h0000_0000 (WIDTH bits), is the value loaded into the PC on reset.
REQ-003 Port CLK, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit, is a synchronous, active-low reset sampled on the rising edge of CLK.
REQ-005 Port PC_input, input, WIDTH bits, is the next program-counter value.
REQ-006 Port PC_output, output, WIDTH bits, is the current program-counter value, driven directly from a register.

Function
REQ-007 The block SHALL hold one WIDTH-bit register, pc_q, and PC_output SHALL equal pc_q at all times.
REQ-008 On a rising CLK edge with reset=1, pc_q SHALL load PC_input, subject to REQ-013.
REQ-009 Latency: a value on PC_input before rising edge N SHALL appear on PC_output after edge N, with exactly one cycle of delay and no combinational path from input to output.
REQ-010 Between rising edges, PC_output SHALL stay stable regardless of changes on PC_input.
REQ-011 PC_input SHALL be treated as unsigned. There is no increment, wrap or overflow logic; all WIDTH bits pass through unchanged, including all-ones.
REQ-012 Before the first rising edge with reset=0, PC_output is undefined. The bench SHALL NOT check it.

Reset
REQ-013 On a rising CLK edge with reset=0, pc_q SHALL load RESET_VALUE, and PC_input SHALL be ignored on that edge.
REQ-014 reset changing between edges SHALL have no effect until the next rising CLK edge.
REQ-015 On the first rising edge after reset returns to 1, pc_q SHALL load PC_input.
REQ-016 Asserting reset mid-operation SHALL override any pending load on that edge.

Configuration
REQ-017 Macro PC_ALIGN_EN: when defined, pc_q SHALL load PC_input with bits [1:0] forced to 0 (word alignment); RESET_VALUE SHALL also be stored with bits [1:0] forced to 0.
REQ-018 When PC_ALIGN_EN is not defined, all WIDTH bits SHALL load unmodified.

Verification
REQ-019 reset=0, PC_input=100 over one rising edge -> PC_output=0.
REQ-020 reset=0 then reset=1, PC_input=100 -> after the next edge PC_output=100. Then PC_input=200 -> after the next edge 200. Then PC_input=300 -> after the next edge 300.
REQ-021 Change PC_input from 300 to 400 mid-cycle -> PC_output stays 300 until the next rising edge, then becomes 400.
REQ-022 reset=0 with PC_input=500 while running -> PC_output=0 after that edge. reset=1 -> PC_output=500 after the next edge.
REQ-023 PC_input=32'hFFFF_FFFF with reset=1 -> PC_output=32'hFFFF_FFFF without the macro, and 32'hFFFF_FFFC with PC_ALIGN_EN defined.
REQ-024 Pulse reset low only between edges, with no rising edge while it is low -> PC_output does not change.
